id_ex_fwd: RTL and testbench

ID_EX_FWD -- requirements
Module: id_ex_fwd

---
 rtl/id_ex_fwd.sv | 191 +++++++++++++++++++
 tb/tb_id_ex_fwd.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd.sv
// rtl/id_ex_fwd.sv - ID/EX pipeline register with EX operand forwarding and load-use hazard detection (option macro: ID_EX_FWD_FWD_EN)
module id_ex_fwd (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_regDst,
    input  logic        id_aluSrc,
    input  logic        id_regWrite,
    input  logic        id_memRead,
    input  logic        id_memWrite,
    input  logic        id_memToReg,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [31:0] id_rsData,
    input  logic [31:0] id_rtData,
    input  logic [31:0] id_imm,
    input  logic [2:0]  id_aluCtl,
    input  logic        exmem_regWrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regWrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [2:0]  ctl,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  shamt,
    output logic        ex_valid,
    output logic        ex_regWrite,
    output logic        ex_memRead,
    output logic        ex_memWrite,
    output logic        ex_memToReg,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_storeData,
    output logic        hazard_stall
);

    logic        valid_q, valid_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        alusrc_q, alusrc_d;
    logic [2:0]  aluctl_q, aluctl_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] rsdata_q, rsdata_d;
    logic [31:0] rtdata_q, rtdata_d;
    logic [31:0] imm_q, imm_d;

    logic        load_use;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Hazard detection: a load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = valid_q && memread_q && (dest_q != 5'd0) && id_valid &&
                   ((dest_q == id_rs) || (dest_q == id_rt));
`ifdef ID_EX_FWD_FWD_EN
        hazard_stall = load_use;
`else
        // Without forwarding, any pending writer of a source register must drain first
        hazard_stall = load_use ||
            (id_valid && (id_rs != 5'd0) &&
             ((valid_q && regwrite_q && (dest_q == id_rs)) ||
              (exmem_regWrite && (exmem_rd == id_rs)))) ||
            (id_valid && (id_rt != 5'd0) &&
             ((valid_q && regwrite_q && (dest_q == id_rt)) ||
              (exmem_regWrite && (exmem_rd == id_rt))));
`endif
    end

    // Next state: flush beats stall, stall beats the hazard bubble, otherwise load from ID
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluctl_d   = aluctl_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        dest_d     = dest_q;
        rsdata_d   = rsdata_q;
        rtdata_d   = rtdata_q;
        imm_d      = imm_q;
        if (flush || (!stall && hazard_stall)) begin
            // Bubble: only side-effecting control is cleared, data fields are left as-is
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
        end else if (!stall) begin
            valid_d    = id_valid;
            regwrite_d = id_valid && id_regWrite;
            memread_d  = id_valid && id_memRead;
            memwrite_d = id_valid && id_memWrite;
            memtoreg_d = id_valid && id_memToReg;
            alusrc_d   = id_aluSrc;
            aluctl_d   = id_aluCtl;
            shamt_d    = id_shamt;
            rs_d       = id_rs;
            rt_d       = id_rt;
            dest_d     = id_regDst ? id_rd : id_rt;
            rsdata_d   = id_rsData;
            rtdata_d   = id_rtData;
            imm_d      = id_imm;
        end
    end

    // ID/EX register bank, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctl_q   <= 3'd0;
            shamt_q    <= 5'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            dest_q     <= 5'd0;
            rsdata_q   <= 32'd0;
            rtdata_q   <= 32'd0;
            imm_q      <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluctl_q   <= aluctl_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dest_q     <= dest_d;
            rsdata_q   <= rsdata_d;
            rtdata_q   <= rtdata_d;
            imm_q      <= imm_d;
        end
    end

    // Operand selection: the younger EX/MEM writer wins, register 0 is never bypassed
    always_comb begin
        rs_val = rsdata_q;
        rt_val = rtdata_q;
`ifdef ID_EX_FWD_FWD_EN
        if (exmem_regWrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
            rs_val = exmem_result;
        end else if (memwb_regWrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
            rs_val = memwb_data;
        end
        if (exmem_regWrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
            rt_val = exmem_result;
        end else if (memwb_regWrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
            rt_val = memwb_data;
        end
`endif
    end

`ifndef ID_EX_FWD_FWD_EN
    // Source register numbers and later-stage values only matter when bypassing is built in
    logic unused_fwd;
    assign unused_fwd = ^{rs_q, rt_q, exmem_result, memwb_regWrite, memwb_rd, memwb_data};
`endif

    assign a            = rs_val;
    assign b            = alusrc_q ? imm_q : rt_val;
    assign ex_storeData = rt_val;
    assign ctl          = aluctl_q;
    assign shamt        = shamt_q;
    assign ex_valid     = valid_q;
    assign ex_regWrite  = regwrite_q;
    assign ex_memRead   = memread_q;
    assign ex_memWrite  = memwrite_q;
    assign ex_memToReg  = memtoreg_q;
    assign ex_dest      = dest_q;

endmodule

// File: tb/tb_id_ex_fwd.sv
// tb/tb_id_ex_fwd.sv - directed and randomized self-checking bench for id_ex_fwd
module tb_id_ex_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        id_valid, id_regDst, id_aluSrc, id_regWrite, id_memRead, id_memWrite, id_memToReg;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rsData, id_rtData, id_imm;
    logic [2:0]  id_aluCtl;
    logic        exmem_regWrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic [2:0]  ctl;
    logic [31:0] a, b, ex_storeData;
    logic [4:0]  shamt, ex_dest;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;
    logic        hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model of the instruction sitting in EX
    logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_alusrc, m_known;
    logic [2:0]  m_ctl;
    logic [4:0]  m_shamt, m_rs, m_rt, m_dest;
    logic [31:0] m_rsd, m_rtd, m_imm;

    always #5 clk = ~clk;

    id_ex_fwd dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_regDst(id_regDst), .id_aluSrc(id_aluSrc),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_rsData(id_rsData), .id_rtData(id_rtData), .id_imm(id_imm),
        .id_aluCtl(id_aluCtl), .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .ctl(ctl), .a(a), .b(b), .shamt(shamt),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg), .ex_dest(ex_dest),
        .ex_storeData(ex_storeData), .hazard_stall(hazard_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_m(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FWD_FWD_EN
        if (exmem_regWrite && exmem_rd != 5'd0 && exmem_rd == r) return exmem_result;
        if (memwb_regWrite && memwb_rd != 5'd0 && memwb_rd == r) return memwb_data;
`endif
        return d;
    endfunction

    function automatic logic reads_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (m_valid && m_rw && m_dest == r) || (exmem_regWrite && exmem_rd == r);
    endfunction

    function automatic logic exp_hazard();
        logic h;
        h = m_valid && m_mr && m_dest != 5'd0 && id_valid && (m_dest == id_rs || m_dest == id_rt);
`ifndef ID_EX_FWD_FWD_EN
        h = h || (id_valid && (reads_pending(id_rs) || reads_pending(id_rt)));
`endif
        return h;
    endfunction

    task automatic model_reset();
        {m_valid, m_rw, m_mr, m_mw, m_mtr, m_alusrc} = '0;
        m_ctl = '0; m_shamt = '0; m_rs = '0; m_rt = '0; m_dest = '0;
        m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_known = 1'b1;
    endtask

    task automatic model_update();
        logic h;
        h = exp_hazard();
        if (flush || (!stall && h)) begin
            {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
            m_known = 1'b0;
        end else if (!stall) begin
            m_valid  = id_valid;
            m_rw     = id_valid & id_regWrite;
            m_mr     = id_valid & id_memRead;
            m_mw     = id_valid & id_memWrite;
            m_mtr    = id_valid & id_memToReg;
            m_alusrc = id_aluSrc;
            m_ctl    = id_aluCtl;
            m_shamt  = id_shamt;
            m_rs     = id_rs;
            m_rt     = id_rt;
            m_dest   = id_regDst ? id_rd : id_rt;
            m_rsd    = id_rsData;
            m_rtd    = id_rtData;
            m_imm    = id_imm;
            m_known  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_all();
        chk("hazard_stall", 32'(hazard_stall), 32'(exp_hazard()));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_regWrite", 32'(ex_regWrite), 32'(m_rw));
        chk("ex_memRead", 32'(ex_memRead), 32'(m_mr));
        chk("ex_memWrite", 32'(ex_memWrite), 32'(m_mw));
        chk("ex_memToReg", 32'(ex_memToReg), 32'(m_mtr));
        if (m_known) begin
            chk("ctl", 32'(ctl), 32'(m_ctl));
            chk("shamt", 32'(shamt), 32'(m_shamt));
            chk("ex_dest", 32'(ex_dest), 32'(m_dest));
            chk("a", a, fwd_m(m_rs, m_rsd));
            chk("b", b, m_alusrc ? m_imm : fwd_m(m_rt, m_rtd));
            chk("ex_storeData", ex_storeData, fwd_m(m_rt, m_rtd));
        end
    endtask

    task automatic clear_inputs();
        {stall, flush} = '0;
        {id_valid, id_regDst, id_aluSrc, id_regWrite, id_memRead, id_memWrite, id_memToReg} = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
        id_rsData = '0; id_rtData = '0; id_imm = '0; id_aluCtl = '0;
        exmem_regWrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regWrite = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic rnd_inputs();
        stall          = ($urandom_range(0, 7) == 0);
        flush          = ($urandom_range(0, 9) == 0);
        id_valid       = ($urandom_range(0, 3) != 0);
        id_regDst      = 1'($urandom_range(0, 1));
        id_aluSrc      = 1'($urandom_range(0, 1));
        id_regWrite    = 1'($urandom_range(0, 1));
        id_memRead     = ($urandom_range(0, 3) == 0);
        id_memWrite    = 1'($urandom_range(0, 1));
        id_memToReg    = 1'($urandom_range(0, 1));
        id_rs          = 5'($urandom_range(0, 3));
        id_rt          = 5'($urandom_range(0, 3));
        id_rd          = 5'($urandom_range(0, 3));
        id_shamt       = 5'($urandom);
        id_rsData      = $urandom;
        id_rtData      = $urandom;
        id_imm         = $urandom;
        id_aluCtl      = 3'($urandom);
        exmem_regWrite = ($urandom_range(0, 3) == 0);
        exmem_rd       = 5'($urandom_range(0, 3));
        exmem_result   = $urandom;
        memwb_regWrite = 1'($urandom_range(0, 1));
        memwb_rd       = 5'($urandom_range(0, 3));
        memwb_data     = $urandom;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        model_reset();
        #12;
        chk("reset ex_valid", 32'(ex_valid), 32'd0);
        chk("reset a", a, 32'd0);
        chk("reset b", b, 32'd0);
        chk("reset storeData", ex_storeData, 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // plain load, no writer match
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
        id_rsData = 32'd5; id_rtData = 32'd7; id_aluCtl = 3'd2; id_aluSrc = 1'b0;
        tick();
        chk("load a", a, 32'd5);
        chk("load b", b, 32'd7);
        chk("load ctl", 32'(ctl), 32'd2);
        check_all();

        // EX/MEM beats MEM/WB on the same register
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd8; id_rsData = 32'h33;
        tick();
        clear_inputs();
        exmem_regWrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
        memwb_regWrite = 1'b1; memwb_rd = 5'd8; memwb_data = 32'h22;
        #1;
`ifdef ID_EX_FWD_FWD_EN
        chk("fwd exmem", a, 32'h11);
`else
        chk("nofwd exmem", a, 32'h33);
`endif
        check_all();
        exmem_regWrite = 1'b0;
        #1;
`ifdef ID_EX_FWD_FWD_EN
        chk("fwd memwb", a, 32'h22);
`else
        chk("nofwd memwb", a, 32'h33);
`endif
        check_all();

        // register 0 is never bypassed
        clear_inputs();
        id_valid = 1'b1;
        tick();
        exmem_regWrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        #1;
        chk("r0 no fwd", a, 32'd0);
        check_all();

        // load-use hazard inserts a bubble
        clear_inputs();
        id_valid = 1'b1; id_memRead = 1'b1; id_regWrite = 1'b1; id_rt = 5'd9; id_rs = 5'd3;
        tick();
        clear_inputs();
        id_valid = 1'b1; id_rt = 5'd9; id_rs = 5'd4;
        #1;
        chk("load-use hazard", 32'(hazard_stall), 32'd1);
        check_all();
        tick();
        chk("bubble ex_valid", 32'(ex_valid), 32'd0);
        chk("bubble ex_memRead", 32'(ex_memRead), 32'd0);
        check_all();

        // flush wins over stall, then stall holds for three edges
        clear_inputs();
        id_valid = 1'b1; id_regWrite = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regDst = 1'b1;
        tick();
        chk("pre-flush ex_valid", 32'(ex_valid), 32'd1);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush+stall ex_valid", 32'(ex_valid), 32'd0);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7; id_regDst = 1'b1;
        id_rsData = 32'hA; id_rtData = 32'hB; id_imm = 32'hC; id_aluSrc = 1'b1;
        id_aluCtl = 3'd5; id_shamt = 5'd4; id_memWrite = 1'b1;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id_rsData = $urandom; id_imm = $urandom; id_aluCtl = 3'(k); id_rd = 5'(k + 10);
            tick();
            chk("stall a", a, 32'hA);
            chk("stall b", b, 32'hC);
            chk("stall ctl", 32'(ctl), 32'd5);
            chk("stall shamt", 32'(shamt), 32'd4);
            chk("stall dest", 32'(ex_dest), 32'd7);
            chk("stall valid", 32'(ex_valid), 32'd1);
            check_all();
        end

        // asynchronous reset mid-stream
        clear_inputs();
        id_valid = 1'b1; id_aluCtl = 3'd6; id_regWrite = 1'b1; id_rd = 5'd12; id_regDst = 1'b1;
        tick();
        chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async reset ex_valid", 32'(ex_valid), 32'd0);
        chk("async reset ctl", 32'(ctl), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        id_valid = 1'b1; id_aluCtl = 3'd3; id_rsData = 32'h44;
        tick();
        chk("post-reset ex_valid", 32'(ex_valid), 32'd1);
        chk("post-reset ctl", 32'(ctl), 32'd3);
        chk("post-reset a", a, 32'h44);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rnd_inputs();
            #1;
            check_all();
            tick();
        end
        #1;
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
